// File: rtl/extended_euclid.sv
// rtl/extended_euclid.sv - iterative extended-Euclid engine with bit-serial restoring division
module extended_euclid #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WORD_WIDTH-1:0]        e,
  input  logic [WORD_WIDTH-1:0]        n,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic signed [WORD_WIDTH-1:0] gcd_o,
  output logic signed [WORD_WIDTH-1:0] coeff_o,
  output logic signed [WORD_WIDTH-1:0] n_o
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam int SW = WORD_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV,
    ST_UPDATE,
    ST_DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] old_r;
  logic [WORD_WIDTH-1:0] r;
  logic [SW-1:0]         old_s;
  logic [SW-1:0]         s;
  logic [SW-1:0]         t;
  logic [WORD_WIDTH:0]   prem;
  logic [CW-1:0]         cnt;

  logic [CW-1:0]         bit_idx;
  logic [WORD_WIDTH:0]   shifted;
  logic [WORD_WIDTH:0]   diff;
  logic                  qbit;
  logic                  op_bad;

  // One restoring-division step: bring down the next dividend bit, trial-subtract the divisor.
  always_comb begin
    bit_idx = CW'(WORD_WIDTH - 1) - cnt;
    shifted = {prem[WORD_WIDTH-1:0], old_r[bit_idx]};
    diff    = shifted - {1'b0, r};
    qbit    = (shifted >= {1'b0, r});
    op_bad  = (n < WORD_WIDTH'(2)) || n[WORD_WIDTH-1] || (e >= n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      gcd_o   <= '0;
      coeff_o <= '0;
      n_o     <= '0;
      old_r   <= '0;
      r       <= '0;
      old_s   <= '0;
      s       <= '0;
      t       <= '0;
      prem    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            n_o  <= $signed(n);
            if (op_bad) begin
              err     <= 1'b1;
              gcd_o   <= '0;
              coeff_o <= '0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              err   <= 1'b0;
              old_r <= e;
              r     <= n;
              old_s <= SW'(1);
              s     <= '0;
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (r == '0) begin
            gcd_o   <= $signed(old_r);
            coeff_o <= $signed(old_s[WORD_WIDTH-1:0]);
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt   <= '0;
            t     <= '0;
            prem  <= '0;
            state <= ST_DIV;
          end
        end

        ST_DIV: begin
          prem <= qbit ? diff : shifted;
          // q*s built MSB-first alongside the quotient; wrap-around is harmless.
          t    <= {t[SW-2:0], 1'b0} + (qbit ? s : '0);
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WORD_WIDTH - 1)) begin
            state <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          old_r <= r;
          r     <= prem[WORD_WIDTH-1:0];
          old_s <= s;
          s     <= old_s - t;
          state <= ST_CHECK;
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extended_euclid.sv
// tb/tb_extended_euclid.sv - directed and randomized checks of extended_euclid against an arithmetic model
module tb_extended_euclid;

  localparam int W    = 32;
  localparam int STEP = W + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [W-1:0]       e_in = '0;
  logic [W-1:0]       n_in = '0;
  logic               busy;
  logic               done;
  logic               err;
  logic signed [W-1:0] gcd_o;
  logic signed [W-1:0] coeff_o;
  logic signed [W-1:0] n_o;

  int n_cmp  = 0;
  int n_fail = 0;

  extended_euclid #(.WORD_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .e       (e_in),
    .n       (n_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .gcd_o   (gcd_o),
    .coeff_o (coeff_o),
    .n_o     (n_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Textbook extended Euclid on wide signed integers.
  task automatic model(input logic [W-1:0] ev, input logic [W-1:0] nv,
                       output bit m_err, output longint m_gcd, output longint m_coeff,
                       output int m_k);
    longint a, b, os, s, q, rem, tmp;
    m_err = (nv < 2) || nv[W-1] || (ev >= nv);
    m_gcd = 0;
    m_coeff = 0;
    m_k = 0;
    if (!m_err) begin
      a = longint'(ev);
      b = longint'(nv);
      os = 1;
      s = 0;
      while (b != 0) begin
        q = a / b;
        rem = a % b;
        a = b;
        b = rem;
        tmp = os - q * s;
        os = s;
        s = tmp;
        m_k++;
      end
      m_gcd = a;
      m_coeff = os;
    end
  endtask

  task automatic launch(input logic [W-1:0] ev, input logic [W-1:0] nv);
    @(negedge clk);
    e_in = ev;
    n_in = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in cycle T0+1; returns in the done cycle (or the cycle after when post is set).
  task automatic finish_op(input string tag, input logic [W-1:0] ev, input logic [W-1:0] nv,
                           input bit post, input bit noise);
    bit     m_err;
    longint m_gcd, m_coeff;
    int     m_k, cyc, exp_cyc;
    logic [W-1:0] g32, c32;
    model(ev, nv, m_err, m_gcd, m_coeff, m_k);
    g32 = m_gcd[W-1:0];
    c32 = m_coeff[W-1:0];
    exp_cyc = m_err ? 1 : 2 + m_k * STEP;
    chk({tag, ".busy_start"}, 64'(busy), 64'(1));
    cyc = 1;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (noise && cyc == 3) begin
        start = 1'b1;
        e_in = 32'd5;
        n_in = 32'd11;
      end
      if (noise && cyc == 6) start = 1'b0;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".busy_done"}, 64'(busy), 64'(1));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
    chk({tag, ".gcd"}, {32'b0, gcd_o}, {32'b0, g32});
    chk({tag, ".coeff"}, {32'b0, coeff_o}, {32'b0, c32});
    chk({tag, ".n_o"}, {32'b0, n_o}, {32'b0, nv});
    if (post) begin
      @(negedge clk);
      chk({tag, ".busy_after"}, 64'(busy), 64'(0));
      chk({tag, ".done_width"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    logic [W-1:0] ev, nv;
    int sel;
    bit seen_done;

    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    chk("rst.gcd", {32'b0, gcd_o}, 64'(0));
    chk("rst.coeff", {32'b0, coeff_o}, 64'(0));
    chk("rst.n_o", {32'b0, n_o}, 64'(0));
    rst_n = 1'b1;

    launch(32'd17, 32'd3120);
    finish_op("rsa", 32'd17, 32'd3120, 1, 0);
    chk("rsa.coeff_const", {32'b0, coeff_o}, {32'b0, 32'hFFFF_FE91});

    launch(32'd6, 32'd9);
    finish_op("noncoprime", 32'd6, 32'd9, 1, 0);

    // Held start: second request is accepted in the first IDLE cycle after done.
    @(negedge clk);
    e_in = 32'd1;
    n_in = 32'd7;
    start = 1'b1;
    @(negedge clk);
    finish_op("b2b1", 32'd1, 32'd7, 0, 0);
    e_in = 32'd2;
    n_in = 32'h7FFF_FFFF;
    @(negedge clk);
    chk("b2b.idle_busy", 64'(busy), 64'(0));
    chk("b2b.idle_done", 64'(done), 64'(0));
    @(negedge clk);
    start = 1'b0;
    finish_op("b2b2", 32'd2, 32'h7FFF_FFFF, 1, 1);

    launch(32'd0, 32'd3120);
    finish_op("zero_e", 32'd0, 32'd3120, 1, 0);

    launch(32'd3, 32'd1);
    finish_op("err_n1", 32'd3, 32'd1, 1, 0);
    launch(32'd9, 32'd9);
    finish_op("err_eqn", 32'd9, 32'd9, 1, 0);
    launch(32'd5, 32'h8000_0001);
    finish_op("err_msb", 32'd5, 32'h8000_0001, 1, 0);

    launch(32'd17, 32'd3120);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.done", 64'(done), 64'(0));
    chk("abort.err", 64'(err), 64'(0));
    chk("abort.gcd", {32'b0, gcd_o}, 64'(0));
    chk("abort.coeff", {32'b0, coeff_o}, 64'(0));
    chk("abort.n_o", {32'b0, n_o}, 64'(0));
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort.no_done", 64'(seen_done), 64'(0));
    launch(32'd17, 32'd3120);
    finish_op("rsa_again", 32'd17, 32'd3120, 1, 0);

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        nv = 32'($urandom_range(0, 1));
        ev = $urandom;
      end else if (sel == 1) begin
        nv = 32'($urandom_range(2, 32'h7FFF_FFFF));
        ev = nv + 32'($urandom_range(0, 3));
      end else if (sel == 2) begin
        nv = 32'h8000_0000 | $urandom;
        ev = 32'($urandom_range(0, 100));
      end else if (sel == 3) begin
        nv = 32'($urandom_range(2, 1000));
        ev = $urandom % nv;
      end else begin
        nv = 32'($urandom_range(2, 32'h7FFF_FFFF));
        ev = $urandom % nv;
      end
      launch(ev, nv);
      finish_op($sformatf("rand%0d", i), ev, nv, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
